// File: rtl/fetch_buf_stage_pkg.sv
// rtl/fetch_buf_stage_pkg.sv - shared constants and FS_TO_DS bus layout for the fetch buffer stage
package fetch_buf_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [15:0] ECODE_ADEF_NUM   = 16'h4000;
    localparam logic [31:0] NOP_INST         = 32'h0340_0000;

    // FS_TO_DS entry layout: {excp_num, excp, inst, pc}
    localparam int FS_PC_LSB   = 0;
    localparam int FS_INST_LSB = 32;
    localparam int FS_EXCP_BIT = 64;
    localparam int FS_NUM_LSB  = 65;
    localparam int FS_TO_DS_W  = 81;

endpackage

// File: rtl/fetch_buf_stage_fifo.sv
// rtl/fetch_buf_stage_fifo.sv - synchronous FIFO with clear, used for the pc-queue and instruction buffer
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // a push at full is only legal when the head leaves in the same cycle
    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
    end

    // pointer and occupancy bookkeeping; clear drops every entry at once
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // storage array, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_buf_stage.sv
// rtl/fetch_buf_stage.sv - multi-outstanding instruction fetch stage with instruction buffer and redirect cancel
module fetch_buf_stage
    import fetch_buf_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [31:0] eentry,
    input  logic [31:0] era,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_excp,
    output logic [15:0] fs_excp_num,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int PCQ_CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IB_CW  = $clog2(IBUF_DEPTH + 1);

    logic [31:0]           fetch_pc;
    logic                  halted;
    logic [PCQ_CW-1:0]     cancel_cnt;
    logic                  pend_valid;
    logic [31:0]           pend_pc;
    logic                  req_hold;

    logic                  flush;
    logic [31:0]           flush_target;

    logic                  pcq_full;
    logic                  pcq_empty;
    logic [PCQ_CW-1:0]     pcq_count;
    logic [31:0]           pcq_head;

    logic                  ib_full;
    logic                  ib_empty;
    logic [IB_CW-1:0]      ib_count;
    logic [FS_TO_DS_W-1:0] ib_head;
    logic [FS_TO_DS_W-1:0] ib_push_data;

    logic                  issue_ok;
    logic                  accept;
    logic                  resp;
    logic                  resp_keep;
    logic                  adef_push;
    logic                  ib_push;
    logic                  ib_pop;
    logic [PCQ_CW-1:0]     outstanding_next;

    // redirect target, exception beats ertn beats branch
    always_comb begin
        flush        = excp_flush | ertn_flush | br_taken;
        flush_target = br_target;
        if (excp_flush) begin
            flush_target = eentry;
        end else if (ertn_flush) begin
            flush_target = era;
        end
    end

    // issue gating reserves a buffer slot for every request in flight; responses and ADEF feed the buffer
    always_comb begin
        issue_ok = !halted && (fetch_pc[1:0] == 2'b00) && !pcq_full &&
                   ((32'(pcq_count) + 32'(ib_count)) < 32'(IBUF_DEPTH));
        inst_sram_req    = !reset && (req_hold || issue_ok);
        accept           = inst_sram_req && inst_sram_addr_ok;
        resp             = inst_sram_data_ok && !pcq_empty;
        resp_keep        = resp && !flush && (cancel_cnt == '0);
        adef_push        = !halted && (fetch_pc[1:0] != 2'b00) && pcq_empty &&
                           (cancel_cnt == '0) && !ib_full && !flush;
        ib_push          = resp_keep || adef_push;
        ib_pop           = !ib_empty && ds_allowin;
        outstanding_next = pcq_count + PCQ_CW'(accept) - PCQ_CW'(resp);

        ib_push_data = '0;
        if (adef_push) begin
            ib_push_data[FS_PC_LSB +: 32]  = fetch_pc;
            ib_push_data[FS_EXCP_BIT]      = 1'b1;
            ib_push_data[FS_NUM_LSB +: 16] = ECODE_ADEF_NUM;
        end else begin
            ib_push_data[FS_PC_LSB +: 32]   = pcq_head;
            ib_push_data[FS_INST_LSB +: 32] = inst_sram_rdata;
        end
    end

    // fetch pointer, pending redirect, stall-on-ADEF and count of responses still to be dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            halted     <= 1'b0;
            cancel_cnt <= '0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            req_hold   <= 1'b0;
        end else begin
            req_hold <= inst_sram_req && !inst_sram_addr_ok;
            if (flush) begin
                halted     <= 1'b0;
                cancel_cnt <= outstanding_next;
                if (inst_sram_req && !inst_sram_addr_ok) begin
                    pend_valid <= 1'b1;
                    pend_pc    <= flush_target;
                end else begin
                    pend_valid <= 1'b0;
                    fetch_pc   <= flush_target;
                end
            end else begin
                cancel_cnt <= cancel_cnt - PCQ_CW'(resp && (cancel_cnt != '0))
                                         + PCQ_CW'(accept && pend_valid);
                if (accept) begin
                    fetch_pc   <= pend_valid ? pend_pc : fetch_pc + 32'd4;
                    pend_valid <= 1'b0;
                end
                if (adef_push) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp),
        .pop_data  (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    fetch_fifo #(
        .WIDTH (FS_TO_DS_W),
        .DEPTH (IBUF_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (ib_push),
        .push_data (ib_push_data),
        .pop       (ib_pop),
        .pop_data  (ib_head),
        .full      (ib_full),
        .empty     (ib_empty),
        .count     (ib_count)
    );

    // decode sees the buffer head; the SRAM port is read-only
    always_comb begin
        fs_to_ds_valid  = !ib_empty;
        fs_pc           = ib_head[FS_PC_LSB +: 32];
        fs_inst         = fs_to_ds_valid ? ib_head[FS_INST_LSB +: 32] : NOP_INST;
        fs_excp         = ib_head[FS_EXCP_BIT];
        fs_excp_num     = ib_head[FS_NUM_LSB +: 16];
        inst_sram_addr  = fetch_pc;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'b10;
        inst_sram_wstrb = 4'b0000;
        inst_sram_wdata = 32'h0;
    end

endmodule

// File: tb/tb_fetch_buf_stage.sv
// tb/tb_fetch_buf_stage.sv - self-checking bench for fetch_buf_stage
module tb_fetch_buf_stage;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int IBUF_DEPTH = 4;
    localparam int MAX_OUT    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        excp_flush = 1'b0, ertn_flush = 1'b0, br_taken = 1'b0;
    logic [31:0] eentry = '0, era = '0, br_target = '0;
    logic        ds_allowin = 1'b0;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc, fs_inst;
    logic        fs_excp;
    logic [15:0] fs_excp_num;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;

    fetch_buf_stage #(
        .RESET_PC(RESET_PC), .IBUF_DEPTH(IBUF_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .eentry(eentry), .era(era), .br_taken(br_taken), .br_target(br_target),
        .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid),
        .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_excp(fs_excp), .fs_excp_num(fs_excp_num),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus knobs
    int          p_addr = 100, p_data = 100, p_allow = 100;
    bit          r_knob = 1'b1;
    bit          k_excp = 0, k_ertn = 0, k_br = 0;
    logic [31:0] k_eentry = '0, k_era = '0, k_brt = '0;

    // reference model state
    logic [31:0] sram_q[$];
    logic [31:0] model_fetch, pend_m, exp_pc, prev_addr, avoid_addr = '1;
    bit          pend_v, halted_m, prev_hold, post_flush, saw_avoid;
    int          acc_total, dlv_total, cyc, first_valid_cyc, rst_cyc;
    logic        last_req, last_valid, last_dlv_excp;
    logic [31:0] last_addr, last_dlv_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = 32'h1c00_0000 + (32'($urandom_range(0, 255)) << 2);
        if ($urandom_range(0, 7) == 0) t = t + 32'd2;
        return t;
    endfunction

    // observe one cycle at the falling edge and advance the model
    task automatic sample();
        logic        acc, flush;
        logic [31:0] tgt;
        last_req   = inst_sram_req;
        last_addr  = inst_sram_addr;
        last_valid = fs_to_ds_valid;
        if (reset) begin
            chk("rst_req", 32'(inst_sram_req), 0);
            if (rst_cyc > 0) chk("rst_valid", 32'(fs_to_ds_valid), 0);
            rst_cyc++;
            sram_q.delete();
            model_fetch = RESET_PC; exp_pc = RESET_PC;
            pend_v = 0; halted_m = 0; prev_hold = 0; post_flush = 0;
            acc_total = 0; dlv_total = 0; cyc = 0; first_valid_cyc = -1;
            return;
        end
        rst_cyc = 0;
        if (prev_hold) begin
            chk("hold_req", 32'(inst_sram_req), 1);
            chk("hold_addr", inst_sram_addr, prev_addr);
        end
        if (inst_sram_req) chk("req_align", 32'(inst_sram_addr[1:0]), 0);
        if (halted_m) chk("halt_req", 32'(inst_sram_req), 0);
        if (post_flush) chk("flush_valid", 32'(fs_to_ds_valid), 0);
        if (fs_to_ds_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        acc = inst_sram_req && inst_sram_addr_ok;
        if (acc) begin
            chk("fetch_addr", inst_sram_addr, model_fetch);
            sram_q.push_back(inst_sram_addr);
            chk("outstanding", 32'(sram_q.size() <= MAX_OUT), 1);
            acc_total++;
            if (inst_sram_addr == avoid_addr) saw_avoid = 1;
            model_fetch = pend_v ? pend_m : inst_sram_addr + 32'd4;
            pend_v = 0;
        end
        if (fs_to_ds_valid && ds_allowin) begin
            dlv_total++;
            last_dlv_pc = fs_pc; last_dlv_excp = fs_excp;
            chk("extra_dlv", 32'(halted_m), 0);
            chk("dlv_pc", fs_pc, exp_pc);
            if (exp_pc[1:0] != 2'b00) begin
                chk("adef_excp", 32'(fs_excp), 1);
                chk("adef_num", 32'(fs_excp_num), 32'h4000);
                halted_m = 1;
            end else begin
                chk("dlv_excp", 32'(fs_excp), 0);
                chk("dlv_inst", fs_inst, hash(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end
        flush = excp_flush || ertn_flush || br_taken;
        tgt = excp_flush ? eentry : (ertn_flush ? era : br_target);
        if (flush) begin
            exp_pc = tgt; halted_m = 0;
            if (inst_sram_req && !inst_sram_addr_ok) begin
                pend_v = 1; pend_m = tgt;
            end else begin
                pend_v = 0; model_fetch = tgt;
            end
        end
        prev_hold  = inst_sram_req && !inst_sram_addr_ok;
        prev_addr  = inst_sram_addr;
        post_flush = flush;
        cyc++;
    endtask

    // one clock: drive inputs just after the rising edge, sample at the falling edge
    task automatic step();
        @(posedge clk);
        #1;
        reset             = r_knob;
        inst_sram_addr_ok = !r_knob && (int'($urandom_range(0, 99)) < p_addr);
        if (!r_knob && sram_q.size() > 0 && int'($urandom_range(0, 99)) < p_data) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = hash(sram_q.pop_front());
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = $urandom;
        end
        ds_allowin = int'($urandom_range(0, 99)) < p_allow;
        excp_flush = !r_knob && k_excp;
        ertn_flush = !r_knob && k_ertn;
        br_taken   = !r_knob && k_br;
        eentry = k_eentry; era = k_era; br_target = k_brt;
        #4;
        sample();
        k_excp = 0; k_ertn = 0; k_br = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_dlv(input int bound);
        int d0, n;
        d0 = dlv_total; n = 0;
        while (dlv_total == d0 && n < bound) begin
            step();
            n++;
        end
        chk("dlv_wait", 32'(dlv_total != d0), 1);
    endtask

    initial begin
        int d0;
        // reset
        r_knob = 1; steps(2); r_knob = 0;

        // streaming with both handshakes always ready
        p_addr = 100; p_data = 100; p_allow = 100;
        step();
        chk("rst_addr", last_addr, RESET_PC);
        chk("rst_first_req", 32'(last_req), 1);
        chk("rst_first_valid", 32'(last_valid), 0);
        steps(13);
        chk("first_valid_cyc", 32'(first_valid_cyc), 2);
        chk("stream_dlv", 32'(dlv_total), 12);
        chk("stream_acc", 32'(acc_total), 14);

        // decode stalled: buffer plus in-flight saturate, then request drops
        p_allow = 0; steps(10);
        chk("fill_level", 32'(acc_total - dlv_total), IBUF_DEPTH);
        chk("fill_req", 32'(last_req), 0);
        p_allow = 100; steps(10);

        // branch with two in flight; both responses are dropped
        p_data = 0; steps(6);
        chk("two_inflight", 32'(sram_q.size()), MAX_OUT);
        k_br = 1; k_brt = 32'h1c00_0100; step();
        steps(2); p_data = 100;
        wait_dlv(20);
        chk("br_first_pc", last_dlv_pc, 32'h1c00_0100);

        // exception while a request waits for addr_ok
        p_addr = 0; steps(4);
        chk("held_req", 32'(last_req), 1);
        k_excp = 1; k_eentry = 32'h1c00_1000; step();
        steps(2); p_addr = 100;
        wait_dlv(30);
        chk("excp_first_pc", last_dlv_pc, 32'h1c00_1000);

        // misaligned branch target raises ADEF and halts until ertn
        p_data = 0; step();
        k_br = 1; k_brt = 32'h1c00_0102; step();
        p_data = 100;
        wait_dlv(30);
        chk("adef_pc", last_dlv_pc, 32'h1c00_0102);
        chk("adef_flag", 32'(last_dlv_excp), 1);
        steps(6);
        chk("adef_halt", 32'(last_req), 0);
        k_ertn = 1; k_era = 32'h1c00_0008; step();
        wait_dlv(30);
        chk("ertn_pc", last_dlv_pc, 32'h1c00_0008);

        // exception and branch together: exception wins
        saw_avoid = 0; avoid_addr = 32'h1c00_3000;
        k_excp = 1; k_eentry = 32'h1c00_2000; k_br = 1; k_brt = 32'h1c00_3000; step();
        wait_dlv(30);
        chk("prio_pc", last_dlv_pc, 32'h1c00_2000);
        steps(20);
        chk("prio_no_br", 32'(saw_avoid), 0);
        avoid_addr = '1;

        // randomized traffic with redirects and a mid-run reset
        for (int i = 0; i < 2500; i++) begin
            if (i % 50 == 0) begin
                p_addr  = int'($urandom_range(20, 100));
                p_data  = int'($urandom_range(20, 100));
                p_allow = int'($urandom_range(20, 100));
            end
            if (i == 1200) begin
                r_knob = 1; steps(2); r_knob = 0;
            end
            if (i == 1300) d0 = dlv_total;
            if ($urandom_range(0, 99) < 3) begin
                k_excp = ($urandom_range(0, 2) == 0);
                k_ertn = ($urandom_range(0, 2) == 0);
                k_br   = ($urandom_range(0, 1) == 0) || (!k_excp && !k_ertn);
                k_eentry = rand_target(); k_era = rand_target(); k_brt = rand_target();
            end
            step();
        end
        chk("rand_liveness", 32'(dlv_total - d0 > 100), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
